// File: rtl/replacer_pkg.sv
// Shared types and constants for the cache victim selector.
package replacer_pkg;

  typedef enum logic {
    PLRU   = 1'b0,
    RANDOM = 1'b1
  } repl_mode_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } repl_state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_replacer_plru_tree.sv
// Tree-PLRU victim decode and path update for one set; purely combinational.
module plru_tree
  import replacer_pkg::*;
#(
  parameter int N_WAYS = 4,
  localparam int LW = clog2(N_WAYS)
) (
  input  logic [N_WAYS-2:0] tree_bits,
  input  logic [N_WAYS-1:0] acc_way,
  output logic [N_WAYS-2:0] tree_next,
  output logic [LW-1:0]     victim_bin
);

  // node k lives at tree_bits[k-1]; the walk descends toward the side the bit names
  always_comb begin : decode
    int   cur;
    logic bitv;
    cur = 1;
    for (int d = 0; d < LW; d++) begin
      bitv = 1'b0;
      for (int j = 0; j < (1 << d); j++) begin
        if ((1 << d) + j == cur) bitv = tree_bits[(1 << d) + j - 1];
      end
      cur = 2 * cur + int'(bitv);
    end
    victim_bin = LW'(cur - N_WAYS);
  end

  always_comb begin : update
    logic [LW-1:0] acc_bin;
    int            leaf;
    acc_bin = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (acc_way[i]) acc_bin = acc_bin | LW'(i);
    end
    leaf      = N_WAYS + int'(acc_bin);
    tree_next = tree_bits;
    if (|acc_way) begin
      for (int d = 0; d < LW; d++) begin
        for (int j = 0; j < (1 << d); j++) begin
          if ((leaf >> (LW - d)) == (1 << d) + j)
            tree_next[(1 << d) + j - 1] = (((leaf >> (LW - d - 1)) & 1) == 0);
        end
      end
    end
  end

endmodule

// File: rtl/cache_replacer.sv
// Victim selector: per-set PLRU tree state with optional LFSR policy and a one-cycle response.
//   state | meaning
//   INIT  | clearing tree state one set per cycle; requests and accesses ignored
//   READY | serving victim requests and recency updates
module cache_replacer
  import replacer_pkg::*;
#(
  parameter int         N_WAYS = 4,
  parameter int         N_SETS = 64,
  parameter repl_mode_t MODE   = PLRU,
  localparam int LW = clog2(N_WAYS),
  localparam int SW = clog2(N_SETS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  output logic              init_busy,
  input  logic              sel_req,
  input  logic [SW-1:0]     sel_set,
  input  logic [N_WAYS-1:0] sel_valid,
  input  logic [N_WAYS-1:0] sel_lock,
  output logic              sel_resp,
  output logic [N_WAYS-1:0] sel_way,
  output logic [LW-1:0]     sel_way_bin,
  output logic              sel_none,
  input  logic              acc_en,
  input  logic [SW-1:0]     acc_set,
  input  logic [N_WAYS-1:0] acc_way
);

  repl_state_t       state_q, state_d;
  logic [SW-1:0]     sweep_q, sweep_d;
  logic              busy, clr_en;
  logic [N_WAYS-2:0] tree_mem [N_SETS];
  logic [15:0]       lfsr_q, lfsr_next;

  logic              ready, acc_onehot, acc_ok, req_ok;
  logic [N_WAYS-2:0] tree_upd, tree_fwd, sel_tree_unused;
  logic [LW-1:0]     plru_bin, upd_victim_unused;

  logic [N_WAYS-1:0] free_ways, unlocked, pick_way;
  logic [LW-1:0]     policy_bin, pick_bin;
  logic              pick_found;

  logic              resp_q, none_q;
  logic [N_WAYS-1:0] way_q;
  logic [LW-1:0]     bin_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    busy    = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      INIT: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        if (sweep_q == SW'(N_SETS - 1)) begin
          state_d = READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      READY: begin
        if (flush) begin
          state_d = INIT;
          sweep_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign ready      = (state_q == READY);
  assign acc_onehot = (acc_way != '0) && ((acc_way & (acc_way - 1'b1)) == '0);
  assign acc_ok     = acc_en && acc_onehot && ready && !flush;
  assign req_ok     = sel_req && ready && !flush;

  plru_tree #(.N_WAYS(N_WAYS)) u_upd (
    .tree_bits  (tree_mem[acc_set]),
    .acc_way    (acc_way),
    .tree_next  (tree_upd),
    .victim_bin (upd_victim_unused)
  );

  // a same-cycle access to the requested set is folded in before the walk
  assign tree_fwd = (acc_ok && (acc_set == sel_set)) ? tree_upd : tree_mem[sel_set];

  plru_tree #(.N_WAYS(N_WAYS)) u_sel (
    .tree_bits  (tree_fwd),
    .acc_way    ('0),
    .tree_next  (sel_tree_unused),
    .victim_bin (plru_bin)
  );

  always_ff @(posedge clk) begin
    if (clr_en) tree_mem[sweep_q] <= '0;
    else if (acc_ok) tree_mem[acc_set] <= tree_upd;
  end

  assign free_ways  = ~sel_valid & ~sel_lock;
  assign unlocked   = ~sel_lock;
  assign policy_bin = (MODE == RANDOM) ? lfsr_q[LW-1:0] : plru_bin;

  always_comb begin
    pick_found = 1'b0;
    pick_bin   = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (!pick_found && free_ways[i]) begin
        pick_found = 1'b1;
        pick_bin   = LW'(i);
      end
    end
    if (!pick_found && unlocked[policy_bin]) begin
      pick_found = 1'b1;
      pick_bin   = policy_bin;
    end
    for (int i = 0; i < N_WAYS; i++) begin
      if (!pick_found && unlocked[i]) begin
        pick_found = 1'b1;
        pick_bin   = LW'(i);
      end
    end
    pick_way = pick_found ? (N_WAYS'(1) << pick_bin) : '0;
  end

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_q <= 1'b0;
      way_q  <= '0;
      bin_q  <= '0;
      none_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else begin
      resp_q <= req_ok;
      way_q  <= req_ok ? pick_way : '0;
      bin_q  <= req_ok ? pick_bin : '0;
      none_q <= req_ok && !pick_found;
      if (req_ok) lfsr_q <= lfsr_next;
    end
  end

  // outputs are forced idle combinationally so they are clean before the first reset edge
  assign init_busy   = busy | ~reset_n;
  assign sel_resp    = resp_q & reset_n;
  assign sel_way     = way_q & {N_WAYS{reset_n}};
  assign sel_way_bin = bin_q & {LW{reset_n}};
  assign sel_none    = none_q & reset_n;

endmodule

// File: tb/tb_cache_replacer.sv
// Bench for cache_replacer: PLRU instance checked against a 4-way tree model, RANDOM instance against an LFSR model.
module tb_cache_replacer;
  import replacer_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, flush;
  logic       init_busy, sel_req, sel_resp, sel_none, acc_en;
  logic [2:0] sel_set, acc_set;
  logic [3:0] sel_valid, sel_lock, sel_way, acc_way;
  logic [1:0] sel_way_bin;

  logic       init_busy_r, sel_req_r, sel_resp_r, sel_none_r, acc_en_r;
  logic [2:0] sel_set_r, acc_set_r;
  logic [3:0] sel_valid_r, sel_lock_r, sel_way_r, acc_way_r;
  logic [1:0] sel_way_bin_r;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sb [$];
  logic [3:0] sb_r [$];
  int         way_cnt [4];

  bit m_root [8];
  bit m_n2 [8];
  bit m_n3 [8];

  always #5 clk = ~clk;

  cache_replacer #(.N_WAYS(4), .N_SETS(8), .MODE(PLRU)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .init_busy(init_busy),
    .sel_req(sel_req), .sel_set(sel_set), .sel_valid(sel_valid), .sel_lock(sel_lock),
    .sel_resp(sel_resp), .sel_way(sel_way), .sel_way_bin(sel_way_bin), .sel_none(sel_none),
    .acc_en(acc_en), .acc_set(acc_set), .acc_way(acc_way)
  );

  cache_replacer #(.N_WAYS(4), .N_SETS(8), .MODE(RANDOM)) dut_rnd (
    .clk(clk), .reset_n(reset_n), .flush(flush), .init_busy(init_busy_r),
    .sel_req(sel_req_r), .sel_set(sel_set_r), .sel_valid(sel_valid_r), .sel_lock(sel_lock_r),
    .sel_resp(sel_resp_r), .sel_way(sel_way_r), .sel_way_bin(sel_way_bin_r), .sel_none(sel_none_r),
    .acc_en(acc_en_r), .acc_set(acc_set_r), .acc_way(acc_way_r)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bin_of(input logic [3:0] w);
    int b;
    b = 0;
    for (int i = 0; i < 4; i++) if (w[i]) b = i;
    return b;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      m_root[s] = 1'b0;
      m_n2[s]   = 1'b0;
      m_n3[s]   = 1'b0;
    end
  endtask

  task automatic model_touch(input int s, input logic [3:0] w);
    if (w[0])      begin m_root[s] = 1'b1; m_n2[s] = 1'b1; end
    else if (w[1]) begin m_root[s] = 1'b1; m_n2[s] = 1'b0; end
    else if (w[2]) begin m_root[s] = 1'b0; m_n3[s] = 1'b1; end
    else           begin m_root[s] = 1'b0; m_n3[s] = 1'b0; end
  endtask

  function automatic logic [3:0] model_pick(input int s, input logic [3:0] valid, input logic [3:0] lock);
    logic [3:0] free;
    int         pol;
    free = ~valid & ~lock;
    for (int i = 0; i < 4; i++) if (free[i]) return 4'(1 << i);
    pol = m_root[s] ? (m_n3[s] ? 3 : 2) : (m_n2[s] ? 1 : 0);
    if (!lock[pol]) return 4'(1 << pol);
    for (int i = 0; i < 4; i++) if (!lock[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  // one clock of stimulus; lit < 0 takes the expected victim from the model
  task automatic step(input bit do_acc, input int aset, input logic [3:0] away,
                      input bit do_sel, input int sset, input logic [3:0] valid,
                      input logic [3:0] lock, input int lit);
    acc_en    = do_acc;
    acc_set   = aset[2:0];
    acc_way   = away;
    sel_req   = do_sel;
    sel_set   = sset[2:0];
    sel_valid = valid;
    sel_lock  = lock;
    if (do_acc && away != 4'b0000 && (away & (away - 4'b0001)) == 4'b0000)
      model_touch(aset, away);
    if (do_sel) sb.push_back((lit >= 0) ? lit[3:0] : model_pick(sset, valid, lock));
    @(posedge clk);
    #1;
    acc_en  = 1'b0;
    sel_req = 1'b0;
  endtask

  task automatic measure_busy(output int n, output int resp_seen);
    n = 0;
    resp_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel_resp) resp_seen++;
      if (init_busy) n++;
      else break;
    end
  endtask

  always @(negedge clk) begin
    if (sel_resp) begin
      if (sb.size() == 0) check("unexpected_resp", 1, 0);
      else begin
        logic [3:0] e;
        e = sb.pop_front();
        check("sel_way", int'(sel_way), int'(e));
        check("sel_way_bin", int'(sel_way_bin), bin_of(e));
        check("sel_none", int'(sel_none), int'(e == 4'b0000));
      end
    end
    if (sel_resp_r) begin
      if (sb_r.size() == 0) check("rnd_unexpected_resp", 1, 0);
      else begin
        logic [3:0] e;
        e = sb_r.pop_front();
        check("rnd_sel_way", int'(sel_way_r), int'(e));
        check("rnd_sel_way_bin", int'(sel_way_bin_r), bin_of(e));
        way_cnt[sel_way_bin_r]++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, r;
    logic [15:0] lfsr_m;

    reset_n = 1'b0; flush = 1'b0;
    sel_req = 1'b1; sel_set = 3'd0; sel_valid = 4'hF; sel_lock = 4'h0;
    acc_en = 1'b0; acc_set = 3'd0; acc_way = 4'h0;
    sel_req_r = 1'b0; sel_set_r = 3'd0; sel_valid_r = 4'hF; sel_lock_r = 4'h0;
    acc_en_r = 1'b0; acc_set_r = 3'd0; acc_way_r = 4'h0;
    for (int i = 0; i < 4; i++) way_cnt[i] = 0;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_busy", int'(init_busy), 1);
    check("rst_sel_resp", int'(sel_resp), 0);
    check("rst_sel_way", int'(sel_way), 0);
    check("rst_sel_way_bin", int'(sel_way_bin), 0);
    check("rst_sel_none", int'(sel_none), 0);

    @(posedge clk); #1;
    reset_n = 1'b1;
    measure_busy(n, r);
    sel_req = 1'b0;
    check("init_sweep_len", n, 8);
    check("init_no_resp", r, 0);
    @(posedge clk); #1;

    // directed PLRU sequence on set 3
    step(0, 0, 4'h0, 1, 3, 4'hF, 4'h0, 4'b0001);
    step(1, 3, 4'b0001, 0, 0, 4'hF, 4'h0, 0);
    step(0, 0, 4'h0, 1, 3, 4'hF, 4'h0, 4'b0100);
    step(1, 3, 4'b0100, 0, 0, 4'hF, 4'h0, 0);
    step(0, 0, 4'h0, 1, 3, 4'hF, 4'h0, 4'b0010);

    // invalid way wins; lock fallbacks; all locked
    step(0, 0, 4'h0, 1, 3, 4'b1011, 4'h0, 4'b0100);
    step(0, 0, 4'h0, 1, 3, 4'hF, 4'b0001, 4'b0010);
    step(0, 0, 4'h0, 1, 1, 4'hF, 4'b0001, 4'b0010);
    step(0, 0, 4'h0, 1, 1, 4'hF, 4'b1111, 4'b0000);
    step(0, 0, 4'h0, 1, 1, 4'b1110, 4'b0001, 4'b0010);

    // same-cycle forwarding, malformed accesses, independent sets in one cycle
    step(1, 5, 4'b0001, 1, 5, 4'hF, 4'h0, 4'b0100);
    step(1, 6, 4'b0011, 0, 0, 4'hF, 4'h0, 0);
    step(1, 6, 4'b0000, 0, 0, 4'hF, 4'h0, 0);
    step(0, 0, 4'h0, 1, 6, 4'hF, 4'h0, 4'b0001);
    step(1, 2, 4'b0010, 1, 4, 4'hF, 4'h0, 4'b0001);
    step(0, 0, 4'h0, 1, 2, 4'hF, 4'h0, 4'b0100);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] aw, vl, lk;
      aw = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      vl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      lk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 7), aw,
           bit'($urandom_range(0, 3) != 0), $urandom_range(0, 7), vl, lk, -1);
    end
    repeat (2) @(posedge clk); #1;

    // flush with a request in the same cycle: request is dropped
    flush = 1'b1; sel_req = 1'b1; sel_set = 3'd3; sel_valid = 4'hF; sel_lock = 4'h0;
    @(posedge clk); #1;
    flush = 1'b0; sel_req = 1'b0;
    model_clear();
    measure_busy(n, r);
    check("flush_sweep_len", n, 8);
    check("flush_no_resp", r, 0);
    @(posedge clk); #1;
    step(0, 0, 4'h0, 1, 3, 4'hF, 4'h0, 4'b0001);
    step(0, 0, 4'h0, 1, 5, 4'hF, 4'h0, 4'b0001);
    step(1, 7, 4'b0001, 0, 0, 4'hF, 4'h0, 0);
    step(0, 0, 4'h0, 1, 7, 4'hF, 4'h0, 4'b0100);
    repeat (2) @(posedge clk); #1;

    // reset pulse four cycles into a sweep restarts it from set 0
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
    measure_busy(n, r);
    check("reset_mid_sweep_len", n, 8);
    @(posedge clk); #1;
    step(0, 0, 4'h0, 1, 7, 4'hF, 4'h0, 4'b0001);
    step(0, 0, 4'h0, 1, 0, 4'hF, 4'h0, 4'b0001);
    repeat (2) @(posedge clk); #1;

    // RANDOM instance: LFSR reseeded by the last reset, no requests since
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 1000; i++) begin
      sel_req_r = 1'b1;
      sel_set_r = 3'($urandom_range(0, 7));
      sb_r.push_back(4'(1 << lfsr_m[1:0]));
      lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      @(posedge clk); #1;
    end
    sel_req_r = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) check($sformatf("rnd_way%0d_min150", i), int'(way_cnt[i] >= 150), 1);

    check("sb_drained", sb.size(), 0);
    check("rnd_sb_drained", sb_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_replacer.md
CACHE_REPLACER -- requirements
Module: cache_replacer

Interface
REQ-001 SHALL have parameter N_WAYS, default 4, ways per set; power of two, 2..16.
REQ-002 SHALL have parameter N_SETS, default 64, sets; power of two, 2..1024.
REQ-003 SHALL have parameter MODE, default PLRU, victim policy; PLRU or RANDOM.
REQ-004 SHALL have ports:
clk  in  1  clock; one clock domain; all state on rising edge
reset_n  in  1  reset; synchronous, active-low
flush  in  1  request re-initialisation of all replacement state
init_busy  out  1  high while state sweep runs
sel_req  in  1  victim request
sel_set  in  log2(N_SETS)  set index
sel_valid  in  N_WAYS  valid bits of the set
sel_lock  in  N_WAYS  ways barred from victimisation
sel_resp  out  1  response strobe
sel_way  out  N_WAYS  one-hot victim
sel_way_bin  out  log2(N_WAYS)  binary victim
sel_none  out  1  no eligible way
acc_en  in  1  recency update (hit or fill)
acc_set  in  log2(N_SETS)  set index
acc_way  in  N_WAYS  one-hot accessed way

Function
REQ-005 SHALL store N_WAYS-1 tree bits per set; node 1 = root; children of node k are 2k and 2k+1; leaves map to ways 0..N_WAYS-1 left to right.
REQ-006 SHALL treat tree bit 0 as victim in the lower half and bit 1 as victim in the upper half.
REQ-007 SHALL, on acc_en, set each node on the path to acc_way to point away from it: lower-half access -> 1, upper-half access -> 0. Off-path bits are unchanged.
REQ-008 SHALL ignore acc_en when acc_way is zero or not one-hot.
REQ-009 SHALL assert sel_resp exactly one cycle after an accepted sel_req, with victim outputs valid only in that cycle.
REQ-010 SHALL base the response on the set state including every acc_en up to and including the request cycle. A same-cycle acc_en to sel_set is forwarded.
REQ-011 SHALL choose the victim in this priority order:
(a) lowest-index way with sel_valid=0 and sel_lock=0;
(b) the policy way, if unlocked;
(c) the lowest-index unlocked way.
REQ-012 SHALL, when all ways are locked, drive sel_none=1, sel_way=0 and sel_way_bin=0.
REQ-013 SHALL, in PLRU mode, derive the policy way by walking the tree from the root.
REQ-014 SHALL, in RANDOM mode, take the policy way from the LFSR low log2(N_WAYS) bits.
REQ-015 SHALL use a 16-bit Galois LFSR with taps x^16+x^14+x^13+x^11+1 and seed 16'hACE1.
REQ-016 SHALL advance the LFSR once per accepted sel_req.
REQ-017 SHALL update tree bits in both modes, so that a runtime MODE change between builds is state-compatible.
REQ-018 SHALL use FSM states INIT and READY:
INIT: write zero to set 0..N_SETS-1, one per cycle; init_busy=1; sel_req and acc_en ignored; sel_resp=0; then go to READY.
READY: on flush, go to INIT with the sweep counter at 0.
REQ-019 SHALL accept sel_req and acc_en only in READY with flush=0.
REQ-020 SHALL have the sweep counter wrap exactly at N_SETS-1, and the INIT duration SHALL be exactly N_SETS cycles.
REQ-021 SHALL, when acc_en and sel_req target different sets in the same cycle, service both in that cycle.

Reset
REQ-022 SHALL, while reset_n=0: enter INIT, zero the sweep counter, seed the LFSR, and drive init_busy=1, sel_resp=0, sel_way=0, sel_way_bin=0, sel_none=0.
REQ-023 SHALL restart the sweep from set 0 when reset is asserted mid-sweep or mid-request; no pending response survives reset.

Structure
REQ-024 SHALL define repl_mode_t (PLRU, RANDOM), the LFSR seed and taps, and a clog2 helper in shared package replacer_pkg.
REQ-025 SHALL implement tree victim decode and path update as one combinational sub-module, plru_tree, parameterised by N_WAYS.
REQ-026 SHALL hold state in a flop-based per-set array with synchronous write and a registered request stage.

Verification (N_WAYS=4, N_SETS=8, PLRU)
REQ-027 Reset release -> init_busy=1 for exactly 8 cycles; sel_req during the sweep -> no sel_resp.
REQ-028 sel_req set 3, valid=1111, lock=0000 -> sel_way=0001. Then acc way0, sel -> 0100. Then acc way2, sel -> 0010.
REQ-029 valid=1011 -> sel_way=0100 regardless of tree. Tree victim way0 with lock=0001 -> 0010. lock=1111 -> sel_none=1, sel_way=0000.
REQ-030 acc_en set 5 way0 in the same cycle as sel_req set 5 (valid=1111) -> sel_way=0100 (forwarded).
REQ-031 reset_n low for one cycle at sweep cycle 4 -> a fresh 8-cycle sweep; flush in READY after accesses -> the next sel on any set returns 0001.
REQ-032 RANDOM mode, 1000 requests -> each way chosen at least 150 times; sequence identical across runs.
